// File: rtl/rtc_calendar.sv
// rtl/rtc_calendar.sv - seconds-tick to calendar time converter with checked software load
// Optional weekday tracking is built when RTC_CALENDAR_WDAY_EN is defined.
module rtc_calendar #(
  parameter int YEAR_BASE  = 2000,
  parameter int YEAR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  tick_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [5:0]            ld_sec_i,
  input  logic [5:0]            ld_min_i,
  input  logic [4:0]            ld_hour_i,
  input  logic [4:0]            ld_day_i,
  input  logic [3:0]            ld_mon_i,
  input  logic [YEAR_WIDTH-1:0] ld_year_i,
`ifdef RTC_CALENDAR_WDAY_EN
  input  logic [2:0]            ld_wday_i,
  output logic [2:0]            wday_o,
`endif
  output logic                  ld_err_o,
  output logic [5:0]            sec_o,
  output logic [5:0]            min_o,
  output logic [4:0]            hour_o,
  output logic [4:0]            day_o,
  output logic [3:0]            mon_o,
  output logic [YEAR_WIDTH-1:0] year_o,
  output logic                  min_p_o,
  output logic                  day_p_o
);

  typedef enum logic {IDLE, CHECK} state_t;
  state_t state, state_nxt;

  logic [5:0]            sh_sec, sh_min;
  logic [4:0]            sh_hour, sh_day;
  logic [3:0]            sh_mon;
  logic [YEAR_WIDTH-1:0] sh_year;
`ifdef RTC_CALENDAR_WDAY_EN
  logic [2:0]            sh_wday;
  logic [2:0]            inc_wday;
`endif

  logic                  pending, pending_nxt;
  logic                  handshake, shadow_ok, commit, step;
  logic                  c_sec, c_min, c_hour, c_day, c_mon;
  logic [4:0]            cur_dim;
  logic [5:0]            inc_sec, inc_min;
  logic [4:0]            inc_hour, inc_day;
  logic [3:0]            inc_mon;
  logic [YEAR_WIDTH-1:0] inc_year;

  // Leap test runs on the absolute year so century rules apply correctly.
  function automatic logic [4:0] dim(input logic [3:0] mon, input logic [YEAR_WIDTH-1:0] yoff);
    logic [31:0] y;
    logic        leap;
    y    = 32'(YEAR_BASE) + 32'(yoff);
    leap = ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) || (y % 32'd400 == 32'd0);
    case (mon)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_valid_i) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_ready_o = (state == IDLE);
    ld_err_o   = (state == CHECK) && !shadow_ok;
  end

  always_comb begin
    shadow_ok = (sh_sec < 6'd60) && (sh_min < 6'd60) && (sh_hour < 5'd24) &&
                (sh_mon >= 4'd1) && (sh_mon <= 4'd12) &&
                (sh_day >= 5'd1) && (sh_day <= dim(sh_mon, sh_year));
`ifdef RTC_CALENDAR_WDAY_EN
    shadow_ok = shadow_ok && (sh_wday <= 3'd6);
`endif
  end

  // A tick that collides with a load is parked and applied once the FSM is back in IDLE.
  always_comb begin
    handshake = (state == IDLE) && ld_valid_i;
    commit    = (state == CHECK) && shadow_ok;
    step      = (state == IDLE) && en_i && (pending || (tick_i && !handshake));
    if (state == CHECK) pending_nxt = pending || (tick_i && en_i);
    else                pending_nxt = handshake && tick_i && en_i;
  end

  always_comb begin
    cur_dim  = dim(mon_o, year_o);
    c_sec    = (sec_o == 6'd59);
    c_min    = c_sec && (min_o == 6'd59);
    c_hour   = c_min && (hour_o == 5'd23);
    c_day    = c_hour && (day_o == cur_dim);
    c_mon    = c_day && (mon_o == 4'd12);
    inc_sec  = c_sec  ? 6'd0 : sec_o + 6'd1;
    inc_min  = c_sec  ? (c_min  ? 6'd0 : min_o + 6'd1)  : min_o;
    inc_hour = c_min  ? (c_hour ? 5'd0 : hour_o + 5'd1) : hour_o;
    inc_day  = c_hour ? (c_day  ? 5'd1 : day_o + 5'd1)  : day_o;
    inc_mon  = c_day  ? (c_mon  ? 4'd1 : mon_o + 4'd1)  : mon_o;
    inc_year = c_mon  ? year_o + 1'b1 : year_o;
`ifdef RTC_CALENDAR_WDAY_EN
    inc_wday = c_hour ? ((wday_o == 3'd6) ? 3'd0 : wday_o + 3'd1) : wday_o;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (handshake) begin
      sh_sec  <= ld_sec_i;
      sh_min  <= ld_min_i;
      sh_hour <= ld_hour_i;
      sh_day  <= ld_day_i;
      sh_mon  <= ld_mon_i;
      sh_year <= ld_year_i;
`ifdef RTC_CALENDAR_WDAY_EN
      sh_wday <= ld_wday_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_o   <= 6'd0;
      min_o   <= 6'd0;
      hour_o  <= 5'd0;
      day_o   <= 5'd1;
      mon_o   <= 4'd1;
      year_o  <= '0;
      pending <= 1'b0;
      min_p_o <= 1'b0;
      day_p_o <= 1'b0;
`ifdef RTC_CALENDAR_WDAY_EN
      wday_o  <= 3'd0;
`endif
    end else begin
      pending <= pending_nxt;
      min_p_o <= step && c_sec;
      day_p_o <= step && c_hour;
      if (commit) begin
        sec_o  <= sh_sec;
        min_o  <= sh_min;
        hour_o <= sh_hour;
        day_o  <= sh_day;
        mon_o  <= sh_mon;
        year_o <= sh_year;
`ifdef RTC_CALENDAR_WDAY_EN
        wday_o <= sh_wday;
`endif
      end else if (step) begin
        sec_o  <= inc_sec;
        min_o  <= inc_min;
        hour_o <= inc_hour;
        day_o  <= inc_day;
        mon_o  <= inc_mon;
        year_o <= inc_year;
`ifdef RTC_CALENDAR_WDAY_EN
        wday_o <= inc_wday;
`endif
      end
    end
  end

endmodule
